hex_scroll_ctrl: RTL
====================

// Module: hex_scroll_ctrl
// PURPOSE
//  Sequencer for the six-digit HEX character display. Holds a 3-character word
//  (2-bit codes: 0='d', 1='E', 2='1', 3=blank) and rotates it around HEX5..HEX0.
//  Advances one position per timed tick or per manual step; 6-position ring,
//  direction selectable. Outputs feed the existing per-digit 2-bit-to-7-seg decoders.
// PARAMETERS
//  TICK_DIV  50000000  clock cycles per automatic advance (1 s at 50 MHz); >=2
//  CNT_W     26        tick counter width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  CLOCK_50  in   1  system clock; all logic on rising edge
//  Resetn    in   1  synchronous, active-low reset
//  En        in   1  1 = auto-scroll (RUN), 0 = paused (PAUSE)
//  Dir       in   1  0 = rotate left (Pos+1), 1 = rotate right (Pos-1)
//  Step      in   1  manual advance request, level input, rising-edge detected
//  Load      in   1  capture Ch3..Ch1 and Load_Pos this cycle
//  Load_Pos  in   3  position to load; values 6,7 load as 0
//  Ch3,Ch2,Ch1 in 2 each  word characters, Ch3 leftmost
//  Pos       out  3  current rotation position, 0..5
//  Tick      out  1  one-cycle pulse on every advance (timed or manual)
//  H5..H0    out  2 each  character code per digit, H5 = leftmost
// BEHAVIOUR
//  - Reset (Resetn=0 at edge): Pos=0, word={3,3,3}, counter=0, Step edge reg=0,
//    state=PAUSE, Tick=0 -> H5..H0 all 3. Reset overrides every other input.
//  - Ring: seq[0..5] = {W3,W2,W1,3,3,3} (W = captured word). Hk = seq[(5-k+Pos) mod 6].
//    H outputs are combinational from registered Pos/word; no extra latency.
//  - FSM: PAUSE -> RUN when En=1 (counter starts at 0); RUN -> PAUSE when En=0
//    (counter cleared, Pos held). Transition takes effect at the sampling edge.
//  - RUN: counter increments each cycle; at count TICK_DIV-1 it returns to 0,
//    Pos advances and Tick=1 that same cycle -> exactly one advance per TICK_DIV cycles.
//  - PAUSE: rising edge of Step (Step=1, previous Step=0) advances Pos once, Tick=1.
//    Step held high gives one advance only. Step ignored in RUN (edge reg still tracks).
//  - Advance: Dir=0: Pos 5->0 wraps; Dir=1: Pos 0->5 wraps. On a wrap, word is
//    recaptured from Ch3..Ch1 in the same edge (no tearing mid-scroll).
//  - Load=1: Pos<=Load_Pos (6,7 -> 0), word<=Ch inputs, counter<=0, Tick=0.
//    Load has priority over timed advance and Step in the same cycle; the Step
//    edge is consumed (not deferred). FSM state still follows En.
//  - Dir change mid-run: applies to next advance; counter not reset.
//  - Tick is registered, asserted for the cycle after the advancing edge, aligned
//    with the new Pos value.
// TESTING (bench uses TICK_DIV=4, CNT_W=3)
//  1 Resetn=0 one edge, En=1 -> Pos=0, Tick=0, H5..H0=3,3,3,3,3,3; stays after release w/ En=0.
//  2 Load=1, Ch3/2/1=0/1/2, Load_Pos=0 -> H5..H0=0,1,2,3,3,3; Load_Pos=7 -> Pos=0.
//  3 En=1,Dir=0 -> Tick every 4 cycles, Pos 0,1..5,0; at Pos=1 H5..H0=1,2,3,3,3,0.
//  4 Dir=1 from Pos=0 -> Pos=5, H5..H0=3,0,1,2,3,3; change Ch to 2/2/2 before wrap
//    -> new word appears only after wrap edge.
//  5 En=0, Step high 10 cycles -> exactly one Tick, Pos+1; Step rise with Load=1,
//    Load_Pos=3 -> Pos=3, no Tick.
//  6 Resetn=0 mid-RUN at count 2 -> next edge Pos=0, H all 3, counter 0, state PAUSE.

Source files
------------

// File: rtl/hex_scroll_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_ctrl_if
//  Description : Control/display bundle between a host and hex_scroll_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
interface hex_scroll_ctrl_if;
    logic       En;
    logic       Dir;
    logic       Step;
    logic       Load;
    logic [2:0] Load_Pos;
    logic [1:0] Ch3;
    logic [1:0] Ch2;
    logic [1:0] Ch1;
    logic [2:0] Pos;
    logic       Tick;
    logic [1:0] H5;
    logic [1:0] H4;
    logic [1:0] H3;
    logic [1:0] H2;
    logic [1:0] H1;
    logic [1:0] H0;

    modport master (
        output En, Dir, Step, Load, Load_Pos, Ch3, Ch2, Ch1,
        input  Pos, Tick, H5, H4, H3, H2, H1, H0
    );

    modport slave (
        input  En, Dir, Step, Load, Load_Pos, Ch3, Ch2, Ch1,
        output Pos, Tick, H5, H4, H3, H2, H1, H0
    );
endinterface
`default_nettype wire

// File: rtl/hex_scroll_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hex_scroll_ctrl
//  Description : Rotates a 3-character word around a six-digit HEX display.
//  Revision    : 1.0  initial release
// ============================================================================
module hex_scroll_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    hex_scroll_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        S_PAUSE = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TICK_DIV - 1);
    localparam logic [2:0]       c_pos_max  = 3'd5;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic [5:0]       word_q, word_d;
    logic             step_prev_q, step_prev_d;
    logic             tick_q, tick_d;

    logic             w_advance;
    logic [5:0]       w_ch_word;
    logic [1:0]       w_h [6];

    assign w_ch_word = {bus.Ch3, bus.Ch2, bus.Ch1};

    always_comb begin
        state_d     = bus.En ? S_RUN : S_PAUSE;
        cnt_d       = '0;
        pos_d       = pos_q;
        word_d      = word_q;
        step_prev_d = bus.Step;
        tick_d      = 1'b0;
        w_advance   = 1'b0;

        if (state_q == S_RUN) begin
            // Leaving RUN clears the counter (default) and never advances.
            if (bus.En) begin
                if (cnt_q == c_cnt_last) begin
                    w_advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            w_advance = bus.Step & ~step_prev_q;
        end

        if (bus.Load) begin
            pos_d  = (bus.Load_Pos > c_pos_max) ? 3'd0 : bus.Load_Pos;
            word_d = w_ch_word;
            cnt_d  = '0;
        end else if (w_advance) begin
            tick_d = 1'b1;
            // The word is only refreshed at the wrap so a scroll pass never tears.
            if (!bus.Dir) begin
                if (pos_q == c_pos_max) begin
                    pos_d  = 3'd0;
                    word_d = w_ch_word;
                end else begin
                    pos_d = pos_q + 3'd1;
                end
            end else begin
                if (pos_q == 3'd0) begin
                    pos_d  = c_pos_max;
                    word_d = w_ch_word;
                end else begin
                    pos_d = pos_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state_q     <= S_PAUSE;
            cnt_q       <= '0;
            pos_q       <= 3'd0;
            word_q      <= 6'h3F;
            step_prev_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            word_q      <= word_d;
            step_prev_q <= step_prev_d;
            tick_q      <= tick_d;
        end
    end

    // Ring slots 0..2 carry the word, slots 3..5 are blank.
    function automatic logic [1:0] ring_char(input logic [2:0] idx, input logic [5:0] w);
        case (idx)
            3'd0:    ring_char = w[5:4];
            3'd1:    ring_char = w[3:2];
            3'd2:    ring_char = w[1:0];
            default: ring_char = 2'd3;
        endcase
    endfunction

    for (genvar k = 0; k < 6; k++) begin : g_digit
        localparam logic [3:0] c_off = 4'(5 - k);
        logic [3:0] w_sum;
        logic [2:0] w_idx;
        assign w_sum  = c_off + {1'b0, pos_q};
        assign w_idx  = (w_sum >= 4'd6) ? 3'(w_sum - 4'd6) : w_sum[2:0];
        assign w_h[k] = ring_char(w_idx, word_q);
    end

    assign bus.Pos  = pos_q;
    assign bus.Tick = tick_q;
    assign bus.H5   = w_h[5];
    assign bus.H4   = w_h[4];
    assign bus.H3   = w_h[3];
    assign bus.H2   = w_h[2];
    assign bus.H1   = w_h[1];
    assign bus.H0   = w_h[0];

endmodule
`default_nettype wire
